// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle fetch/execute/memory sequencer for a Hack-style
//               datapath (PC, A/D registers, ALU, data memory).
// Revision    : 1.0 - initial release
// ============================================================================

module pc_sequencer #(
    parameter int BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_req,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    input  logic        zr,
    input  logic        ng,
    output logic        pc_reset,
    output logic        pc_load,
    output logic        pc_inc,
    output logic        a_load,
    output logic        a_sel,
    output logic        d_load,
    output logic        am_sel,
    output logic [5:0]  alu_ctrl,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_MEM   = 3'd4
    } state_t;

    localparam logic [3:0] C_BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] retired_q, retired_d;

    logic w_needs_mem;
    logic w_jump;
    logic w_writeback;
    logic w_retire;
    logic w_unused_ir;

    assign w_needs_mem = ir_q[12] | ir_q[3];
    assign w_jump      = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);
    assign w_unused_ir = ^ir_q[14:13];

    // Strobes are decoded from the registered state so that reset drops any
    // outstanding request at once and writeback can react to same-cycle
    // mem_ready and ALU flags.
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        ir_d        = ir_q;
        w_writeback = 1'b0;
        w_retire    = 1'b0;
        instr_req   = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        pc_reset    = 1'b0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        a_load      = 1'b0;
        a_sel       = 1'b0;
        d_load      = 1'b0;
        am_sel      = 1'b0;
        alu_ctrl    = 6'd0;

        case (state_q)
            ST_BOOT: begin
                pc_reset = 1'b1;
                if (boot_cnt_q == C_BOOT_LAST) begin
                    state_d = run ? ST_FETCH : ST_IDLE;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    instr_req = 1'b1;
                    if (instr_valid) begin
                        ir_d    = instr;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (!ir_q[15]) begin
                    a_load   = 1'b1;
                    pc_inc   = 1'b1;
                    w_retire = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    alu_ctrl = ir_q[11:6];
                    am_sel   = ir_q[12];
                    if (w_needs_mem) begin
                        state_d = ST_MEM;
                    end else begin
                        w_writeback = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end
            end
            ST_MEM: begin
                alu_ctrl  = ir_q[11:6];
                am_sel    = ir_q[12];
                mem_req   = 1'b1;
                mem_write = ir_q[3];
                if (mem_ready) begin
                    w_writeback = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // The PC samples A on this same edge, so a jump targets the old A.
        if (w_writeback) begin
            d_load   = ir_q[4];
            a_load   = ir_q[5];
            a_sel    = 1'b1;
            pc_load  = w_jump;
            pc_inc   = ~w_jump;
            w_retire = 1'b1;
        end
    end

    assign retired_d = w_retire ? (retired_q + 16'd1) : retired_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= 4'd0;
            ir_q       <= 16'd0;
            retired_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            ir_q       <= ir_d;
            retired_q  <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control sequencer for the Hack-style CPU datapath built around the 16-bit program counter, A/D registers and ALU.
- Fetches each instruction through a request/valid handshake and holds it in an internal IR.
- Drives the PC control inputs (reset/load/inc), register loads and ALU control word, and the data-memory request; evaluates jump conditions from the ALU flags.
- Sits between instruction memory, data memory and the existing datapath blocks.

Parameters:
BOOT_CYCLES, 2, cycles pc_reset is held after reset release (range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  1 = execute; 0 = stop at next instruction boundary
instr  input  16  instruction word from instruction memory
instr_valid  input  1  instr valid; completes fetch handshake
instr_req  output  1  fetch request to instruction memory (address = current PC out)
mem_ready  input  1  data-memory access complete
mem_req  output  1  data-memory access request (address = A register)
mem_write  output  1  write qualifier for mem_req (writes ALU result to M)
zr  input  1  ALU zero flag
ng  input  1  ALU negative flag
pc_reset  output  1  to PC reset input
pc_load  output  1  to PC load input (in = A register)
pc_inc  output  1  to PC inc input
a_load  output  1  load A register
a_sel  output  1  A source: 0 = IR immediate, 1 = ALU out
d_load  output  1  load D register
am_sel  output  1  ALU y operand: 0 = A, 1 = M (IR[12])
alu_ctrl  output  6  ALU zx,nx,zy,ny,f,no = IR[11:6]
state  output  3  current state encoding (debug)
retired  output  16  count of completed instructions

Behaviour:
- States and encodings: BOOT=0, IDLE=1, FETCH=2, EXEC=3, MEM=4. Synchronous FSM on rising clk.
- Reset asserted (reset=0):
  - State forced to BOOT immediately; boot counter=0, IR=0, retired=0.
  - All strobes 0 except pc_reset=1.
  - Any in-flight fetch or memory request is abandoned (instr_req and mem_req drop asynchronously).
- BOOT: pc_reset=1 for BOOT_CYCLES rising edges after reset release, then IDLE if run=0, else FETCH.
- IDLE: all strobes 0; go to FETCH when run=1.
- FETCH:
  - instr_req=1 until the cycle instr_valid=1.
  - On that edge: IR<=instr, next state EXEC.
  - If run=0 on entry with no handshake yet: back to IDLE, instr_req=0.
  - An instr_valid arriving outside FETCH is ignored.
- EXEC:
  - A-instruction (IR[15]=0):
    - a_load=1, a_sel=0, pc_inc=1 for one cycle; retired+1; next state FETCH.
  - C-instruction (IR[15]=1; IR[14:13] ignored):
    - alu_ctrl=IR[11:6] and am_sel=IR[12] are driven in EXEC and MEM.
    - If IR[12]=1 or IR[3]=1, go to MEM with no writeback this cycle.
    - Otherwise writeback this cycle: d_load=IR[4], a_load=IR[5], a_sel=1, jump resolution, retired+1, next state FETCH.
- MEM:
  - mem_req=1, mem_write=IR[3], held stable until mem_ready=1.
  - In the mem_ready cycle: writeback and jump resolution as in EXEC, retired+1, next state FETCH.
  - mem_ready outside MEM is ignored.
- Jump resolution, in the writeback cycle only, using zr/ng from that cycle:
  - jump = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr).
  - pc_load=jump, pc_inc=~jump.
  - The PC target is the A value before that cycle's a_load takes effect.
- Invariants:
  - Exactly one of pc_load/pc_inc pulses per retired instruction, for exactly one cycle.
  - pc_load and pc_inc are never high together and never high with pc_reset.
  - mem_req and instr_req are never high together.
- run=0 mid-instruction: the current instruction completes; the FSM stops in IDLE at the next FETCH entry.
- retired wraps 0xFFFF -> 0x0000.
- Minimum latency:
  - A-instr or memory-free C-instr: 2 cycles (FETCH with immediate valid, EXEC).
  - Memory C-instr: 3 cycles.

Test Plan:
- Reset held low 3 cycles, released, run=1, BOOT_CYCLES=2 -> pc_reset=1 through 2 edges after release, then instr_req=1; state sequence 0,0,2.
- Fetch 0x0005 with instr_valid delayed 3 cycles -> instr_req held 3 cycles; EXEC: a_load=1, a_sel=0, pc_inc=1 one cycle; retired=1.
- Fetch 0xEC10 (D=A) -> no MEM state; d_load=1, a_sel=1, alu_ctrl=6'b110000, pc_inc=1; 2-cycle instruction.
- Fetch 0xE308 (M=D), mem_ready after 2 cycles -> mem_req=1 and mem_write=1 for 3 cycles; writeback in ready cycle; pc_inc=1.
- Fetch 0xE302 (D;JEQ): zr=1 -> pc_load=1, pc_inc=0; repeat with zr=0, ng=1 -> pc_inc=1. Then 0xE307 (JMP) -> pc_load=1.
- Reset asserted during MEM with mem_req=1 -> mem_req=0 and pc_reset=1 in the same cycle, state=0, retired=0. Separately, run dropped during EXEC -> instruction retires, state goes IDLE, no instr_req.
